// File: rtl/crank_wheel_gen.sv
`default_nettype none
// ============================================================================
//  Module   : crank_wheel_gen
//  Purpose  : 60-2 crankshaft tooth-wheel emulator. Produces the crank sensor
//             waveform with a programmable tooth pitch (in clk cycles), plus
//             tooth position, gap flag and a once-per-revolution strobe.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   module clock
//    rst          in   synchronous active-high reset
//    ena          in   run enable (0 = idle)
//    period_in    in   requested tooth pitch in clk cycles
//    period_load  in   strobe: capture period_in into the shadow register
//    cap_inv      in   output polarity (0 = tooth high, 1 = tooth low)
//    cap_out      out  emulated crank sensor signal (registered)
//    tooth_num    out  current tooth position 0..TEETH_TOTAL-1
//    gap          out  high while on a missing-tooth position
//    rev_strobe   out  one-cycle pulse on the first cycle of tooth 0
//    running      out  generator is not idle
// ============================================================================
module crank_wheel_gen #(
   parameter int PERIOD_WIDTH  = 24,
   parameter int TCNT_WIDTH    = 6,
   parameter int TEETH_TOTAL   = 60,
   parameter int TEETH_MISSING = 2,
   parameter int PERIOD_MIN    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   input  logic [PERIOD_WIDTH-1:0] period_in,
   input  logic                    period_load,
   input  logic                    cap_inv,
   output logic                    cap_out,
   output logic [TCNT_WIDTH-1:0]   tooth_num,
   output logic                    gap,
   output logic                    rev_strobe,
   output logic                    running
);

   localparam logic [PERIOD_WIDTH-1:0] P_MIN      = PERIOD_WIDTH'(PERIOD_MIN);
   localparam logic [TCNT_WIDTH-1:0]   LAST_TOOTH = TCNT_WIDTH'(TEETH_TOTAL - 1);
   localparam logic [TCNT_WIDTH-1:0]   FIRST_GAP  = TCNT_WIDTH'(TEETH_TOTAL - TEETH_MISSING);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      TOOTH_ON  = 2'd1,
      TOOTH_OFF = 2'd2,
      GAP       = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [PERIOD_WIDTH-1:0] phase, phase_nxt;
   logic [PERIOD_WIDTH-1:0] period_act, period_act_nxt;
   logic [PERIOD_WIDTH-1:0] shadow, shadow_nxt;
   logic [PERIOD_WIDTH-1:0] period_clamped;
   logic [PERIOD_WIDTH-1:0] half;
   logic [TCNT_WIDTH-1:0]   tooth, tooth_nxt, tooth_inc;
   logic                    pitch_end, on_end, next_is_gap;
   logic                    cap_nxt, gap_nxt, rev_nxt;

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      period_clamped = (period_in < P_MIN) ? P_MIN : period_in;
      // A load coinciding with a pitch boundary is forwarded so the new
      // pitch takes effect on the very next pitch.
      shadow_nxt     = period_load ? period_clamped : shadow;
      half           = period_act >> 1;
      pitch_end      = (phase == (period_act - PERIOD_WIDTH'(1)));
      on_end         = (phase == (half - PERIOD_WIDTH'(1)));
      tooth_inc      = (tooth == LAST_TOOTH) ? '0 : tooth + TCNT_WIDTH'(1);
      next_is_gap    = (tooth_inc >= FIRST_GAP);

      state_nxt      = state;
      phase_nxt      = phase;
      tooth_nxt      = tooth;
      period_act_nxt = period_act;
      rev_nxt        = 1'b0;

      if (!ena) begin
         // Abort immediately; no partial-tooth completion.
         state_nxt = IDLE;
         phase_nxt = '0;
         tooth_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt      = TOOTH_ON;
               phase_nxt      = '0;
               tooth_nxt      = '0;
               period_act_nxt = shadow_nxt;
               rev_nxt        = 1'b1;
            end
            TOOTH_ON, TOOTH_OFF, GAP: begin
               if (pitch_end) begin
                  phase_nxt      = '0;
                  tooth_nxt      = tooth_inc;
                  period_act_nxt = shadow_nxt;
                  state_nxt      = next_is_gap ? GAP : TOOTH_ON;
                  rev_nxt        = (tooth_inc == '0);
               end else begin
                  phase_nxt = phase + PERIOD_WIDTH'(1);
                  // H-1 is always below P-1 because P >= PERIOD_MIN.
                  if ((state == TOOTH_ON) && on_end) begin
                     state_nxt = TOOTH_OFF;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               phase_nxt = '0;
               tooth_nxt = '0;
            end
         endcase
      end

      cap_nxt = (state_nxt == TOOTH_ON) ^ cap_inv;
      gap_nxt = (state_nxt == GAP);
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= '0;
         tooth      <= '0;
         period_act <= P_MIN;
         shadow     <= P_MIN;
         cap_out    <= cap_inv;
         gap        <= 1'b0;
         rev_strobe <= 1'b0;
      end else begin
         state      <= state_nxt;
         phase      <= phase_nxt;
         tooth      <= tooth_nxt;
         period_act <= period_act_nxt;
         shadow     <= shadow_nxt;
         cap_out    <= cap_nxt;
         gap        <= gap_nxt;
         rev_strobe <= rev_nxt;
      end
   end

   assign tooth_num = tooth;
   assign running   = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_crank_wheel_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crank_wheel_gen
//  Purpose  : Self-checking bench for crank_wheel_gen. A behavioural model
//             tracks (running, tooth, phase, pitch) arithmetically and the
//             expected outputs are derived from the wheel geometry.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crank_wheel_gen;

   localparam int PW = 24;
   localparam int TW = 6;
   localparam int TT = 60;
   localparam int TM = 2;
   localparam int PMIN = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ena = 1'b0;
   logic [PW-1:0] period_in = '0;
   logic          period_load = 1'b0;
   logic          cap_inv = 1'b0;
   logic          cap_out;
   logic [TW-1:0] tooth_num;
   logic          gap;
   logic          rev_strobe;
   logic          running;

   int n_checks = 0;
   int n_pass   = 0;

   // behavioural model state
   bit m_run   = 1'b0;
   int m_tooth = 0;
   int m_phase = 0;
   int m_p     = PMIN;
   int m_sh    = PMIN;
   bit m_inv   = 1'b0;

   crank_wheel_gen #(
      .PERIOD_WIDTH (PW),
      .TCNT_WIDTH   (TW),
      .TEETH_TOTAL  (TT),
      .TEETH_MISSING(TM),
      .PERIOD_MIN   (PMIN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .period_in  (period_in),
      .period_load(period_load),
      .cap_inv    (cap_inv),
      .cap_out    (cap_out),
      .tooth_num  (tooth_num),
      .gap        (gap),
      .rev_strobe (rev_strobe),
      .running    (running)
   );

   always #5 clk = ~clk;

   // Advance one clock and update the model from the inputs sampled at the edge.
   task automatic step();
      int pin, newsh;
      @(posedge clk);
      pin   = int'(period_in);
      newsh = period_load ? ((pin < PMIN) ? PMIN : pin) : m_sh;
      m_inv = cap_inv;
      if (rst) begin
         m_run = 0; m_tooth = 0; m_phase = 0; m_p = PMIN; m_sh = PMIN;
      end else begin
         if (!ena) begin
            m_run = 0; m_tooth = 0; m_phase = 0;
         end else if (!m_run) begin
            m_run = 1; m_tooth = 0; m_phase = 0; m_p = newsh;
         end else if (m_phase == m_p - 1) begin
            m_phase = 0; m_tooth = (m_tooth + 1) % TT; m_p = newsh;
         end else begin
            m_phase++;
         end
         m_sh = newsh;
      end
      #1;
   endtask

   // Expected {cap_out, gap, rev_strobe, running, tooth_num} from geometry.
   function automatic logic [9:0] exp_vec();
      logic lvl;
      if (!m_run) return {m_inv, 1'b0, 1'b0, 1'b0, 6'd0};
      lvl = (m_tooth < TT - TM) && (m_phase < m_p / 2);
      return {lvl ^ m_inv, (m_tooth >= TT - TM), (m_tooth == 0 && m_phase == 0),
              1'b1, 6'(m_tooth)};
   endfunction

   function automatic logic [9:0] dut_vec();
      return {cap_out, gap, rev_strobe, running, tooth_num};
   endfunction

   task automatic test_reset();
      rst = 1; ena = 1; cap_inv = 0;
      step(); step();
      n_checks++;
      if (dut_vec() !== 10'b0) $display("FAIL reset_inv0 got=%b want=%b", dut_vec(), 10'b0);
      else n_pass++;
      cap_inv = 1;
      step();
      n_checks++;
      if (dut_vec() !== {1'b1, 9'b0}) $display("FAIL reset_inv1 got=%b want=%b", dut_vec(), {1'b1, 9'b0});
      else n_pass++;
      cap_inv = 0; ena = 0;
      step();
      rst = 0;
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL reset_release got=%b want=%b", dut_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_basic();
      int rises = 0, gapc = 0, low_run = 0, max_low = 0, rev_at0 = -1, rev_at1 = -1;
      logic prev = 1'b0;
      period_in = 8; period_load = 1; ena = 1;
      for (int c = 0; c < 2 * TT * 8; c++) begin
         step();
         period_load = 0;
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL basic c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
         else n_pass++;
         if (c < TT * 8) begin
            if (cap_out && !prev) rises++;
            if (gap) gapc++;
            low_run = cap_out ? 0 : low_run + 1;
            if (low_run > max_low) max_low = low_run;
         end
         if (rev_strobe) begin
            if (rev_at0 < 0) rev_at0 = c; else if (rev_at1 < 0) rev_at1 = c;
         end
         prev = cap_out;
      end
      n_checks++;
      if (rises !== TT - TM) $display("FAIL basic_pulses got=%0d want=%0d", rises, TT - TM); else n_pass++;
      n_checks++;
      if (gapc !== TM * 8) $display("FAIL basic_gap_cycles got=%0d want=%0d", gapc, TM * 8); else n_pass++;
      n_checks++;
      if (max_low !== 4 + TM * 8) $display("FAIL basic_gap_low got=%0d want=%0d", max_low, 4 + TM * 8); else n_pass++;
      n_checks++;
      if (rev_at1 - rev_at0 !== TT * 8) $display("FAIL basic_rev_interval got=%0d want=%0d", rev_at1 - rev_at0, TT * 8);
      else n_pass++;
   endtask

   task automatic test_period_change();
      int t10 = 0, hi11 = 0;
      for (int g = 0; g < 2000 && !(m_tooth == 10 && m_phase == 2); g++) step();
      period_in = 12; period_load = 1;
      for (int c = 0; c < 60; c++) begin
         step();
         period_load = 0;
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL pchg c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
         else n_pass++;
         if (tooth_num == 10) t10++;
         if (tooth_num == 11 && cap_out) hi11++;
      end
      n_checks++;
      if (t10 !== 5) $display("FAIL pchg_tooth10_rest got=%0d want=5", t10); else n_pass++;
      n_checks++;
      if (hi11 !== 6) $display("FAIL pchg_tooth11_high got=%0d want=6", hi11); else n_pass++;
   endtask

   task automatic test_clamp();
      int vals[3] = '{1, 0, 5};
      foreach (vals[i]) begin
         period_in = PW'(vals[i]); period_load = 1;
         for (int c = 0; c < 40; c++) begin
            step();
            period_load = 0;
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL clamp v=%0d c=%0d got=%b want=%b", vals[i], c, dut_vec(), exp_vec());
            else n_pass++;
         end
      end
   endtask

   task automatic test_ena_drop();
      period_in = 8; period_load = 1;
      step(); period_load = 0;
      for (int g = 0; g < 3000 && !(m_tooth == 30 && m_phase == 1); g++) step();
      ena = 0;
      step();
      n_checks++;
      if ({cap_out, tooth_num, running} !== 8'b0) $display("FAIL ena_drop got=%b want=%b", {cap_out, tooth_num, running}, 8'b0);
      else n_pass++;
      step();
      ena = 1;
      step();
      n_checks++;
      if ({rev_strobe, cap_out, running, tooth_num} !== {3'b111, 6'd0})
         $display("FAIL ena_restart got=%b want=%b", {rev_strobe, cap_out, running, tooth_num}, {3'b111, 6'd0});
      else n_pass++;
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL ena_restart_model got=%b want=%b", dut_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_inv_and_rst();
      cap_inv = 1;
      for (int c = 0; c < 600; c++) begin
         step();
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL inv c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
         else n_pass++;
      end
      for (int g = 0; g < 3000 && !(m_tooth == TT - 1 && m_phase == 3); g++) step();
      rst = 1; period_in = 20; period_load = 1;
      step();
      rst = 0; period_load = 0; cap_inv = 0; ena = 0;
      n_checks++;
      if (dut_vec() !== {1'b1, 9'b0}) $display("FAIL rst_mid_gap got=%b want=%b", dut_vec(), {1'b1, 9'b0});
      else n_pass++;
      step();
      ena = 1;
      for (int c = 0; c < 12; c++) begin
         step();
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL rst_recover c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
         else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         ena         = ($urandom % 80) != 0;
         period_load = ($urandom % 20) == 0;
         period_in   = PW'($urandom % 13);
         if (($urandom % 50) == 0) cap_inv = ~cap_inv;
         rst         = ($urandom % 700) == 0;
         step();
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL random c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
         else n_pass++;
      end
      rst = 0; period_load = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_period_change();
      test_clamp();
      test_ena_drop();
      test_inv_and_rst();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/crank_wheel_gen.md
Name: crank_wheel_gen

Overview:
Synthesizable 60-2 crankshaft tooth-wheel emulator. It is the transmitter side of the angle-generator capture path. It produces the crank sensor waveform that hwag_core consumes on cap, with a programmable tooth pitch in clock cycles, so the angle generator can run closed-loop on the bench and in HIL without an engine. It also exports tooth position and a revolution strobe as the reference for checking hwag_core sync and angle output.

Parameters:
PERIOD_WIDTH, 24, width of the tooth-pitch value in clk cycles (matches the capture counter width)
TCNT_WIDTH, 6, width of the tooth position counter
TEETH_TOTAL, 60, tooth positions per revolution, including missing teeth
TEETH_MISSING, 2, missing teeth at the end of the revolution (positions TEETH_TOTAL-TEETH_MISSING .. TEETH_TOTAL-1)
PERIOD_MIN, 4, minimum effective pitch; smaller loaded values are clamped to this

Ports:
clk  input  1  module clock
rst  input  1  reset, synchronous, active-high
ena  input  1  run enable; 0 = idle
period_in  input  PERIOD_WIDTH  requested tooth pitch in clk cycles
period_load  input  1  one-cycle strobe; captures period_in into the shadow register
cap_inv  input  1  output polarity; 0 = tooth active-high, 1 = tooth active-low
cap_out  output  1  emulated crank sensor signal (registered)
tooth_num  output  TCNT_WIDTH  current tooth position 0..TEETH_TOTAL-1
gap  output  1  high while the current position is a missing tooth
rev_strobe  output  1  one-cycle pulse on the first cycle of tooth 0
running  output  1  generator is not in IDLE

Behaviour:
- Single clock domain clk. rst is synchronous and active-high and overrides all other inputs.
- Reset values:
  - State IDLE; cap_out = cap_inv; tooth_num = 0; gap = 0; rev_strobe = 0; running = 0.
  - Shadow period = PERIOD_MIN; active period = PERIOD_MIN; phase counter = 0.
- Shadow period:
  - On period_load, shadow <= max(period_in, PERIOD_MIN).
  - The shadow is copied to the active period only at a pitch boundary: the cycle where phase = P-1, or the IDLE->running transition.
  - If period_load coincides with a boundary, the new value is used for the pitch that starts on the next cycle.
  - The active period never changes mid-pitch.
- Pitch geometry, with P = active period and H = P>>1 (floor):
  - Normal tooth k (0 .. TEETH_TOTAL-TEETH_MISSING-1): active level for phase 0..H-1, inactive for phase H..P-1.
  - Missing positions: inactive for the whole pitch; gap = 1.
- State machine:
  - IDLE: ena=1 -> TOOTH_ON, with tooth_num=0, phase=0 and rev_strobe=1 on the first running cycle.
  - TOOTH_ON: phase = H-1 -> TOOTH_OFF.
  - TOOTH_OFF: phase = P-1 -> next position. Go to TOOTH_ON if the next position is normal, GAP if missing.
  - GAP: phase = P-1 -> next position. After the last position, wrap tooth_num to 0, go to TOOTH_ON and pulse rev_strobe.
  - Any state with ena=0 -> IDLE on the next cycle. Counters are cleared, cap_out returns to the inactive level, and there is no partial-tooth completion.
- Phase counter: counts 0..P-1 and wraps to 0 at the pitch boundary.
- tooth_num: increments at each boundary and wraps TEETH_TOTAL-1 -> 0.
- Latency: ena sampled high at cycle N gives cap_out at the active level from cycle N+1. All outputs are registered and glitch-free.
- cap_out = level XOR cap_inv. A cap_inv change is reflected one cycle later and does not disturb the counters.
- Resulting waveform:
  - One revolution = TEETH_TOTAL*P cycles.
  - Inactive run across the gap = (P-H) + TEETH_MISSING*P cycles.
  - Period between like edges across the gap = (TEETH_MISSING+1)*P.
- rst mid-operation: returns to the reset values on the next edge regardless of ena or period_load in the same cycle.

Test Plan:
- period_in=8 loaded, ena=1, cap_inv=0 -> 58 pulses (4 high/4 low), then cap_out low 20 cycles; rev_strobe every 480 cycles; gap high for 16 cycles per revolution.
- P=8 running; period_load 12 at phase 2 of tooth 10 -> tooth 10 stays 8 cycles; tooth 11 onward 6 high/6 low.
- period_in=1 and period_in=0 loaded -> effective P=4, 2 high/2 low; period_in=5 -> 2 high/3 low.
- ena dropped at tooth 30 phase 1 -> next cycle cap_out=0, tooth_num=0, running=0; ena re-raised -> rev_strobe and tooth 0 active on the next cycle.
- cap_inv=1, P=8 -> waveform is the inverse of the first scenario; tooth_num, gap and rev_strobe are identical. rst asserted mid-gap -> all outputs at reset values on the next cycle.
- Loopback into hwag_core (cap_edge_sel=1), P=100 -> hwag_start asserts within the second revolution and stays high. Falling-edge interval across the gap measures 300.
